branch_ctrl: RTL and testbench

- Sequencing controller for the branch comparator in the RV32I core's execute stage.
- Accepts one branch/jump at a time from decode over a valid/ready handshake.
- Drives the comparator's unsigned-select input and samples its equal/less-than results to resolve taken/not-taken.
- On a taken branch, issues a one-cycle PC redirect followed by a parameterised front-end flush window.

---
 rtl/branch_ctrl_pkg.sv | 21 ++
 rtl/branch_decide.sv | 32 +++
 rtl/branch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the execute-stage branch controller: funct3 codes,
// controller state encoding and the flush counter width.
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_REDIR = 2'd2,
    ST_FLUSH = 2'd3
  } brState_t;

endpackage

// File: rtl/branch_decide.sv
// Combinational branch outcome: maps funct3 plus comparator flags to
// taken/illegal. Jumps are always taken and never flagged illegal.
module branch_decide
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       isJump,
  input  logic       eq,
  input  logic       lt,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = lt;
      F3_BGEU: taken = !lt;
      default: illegal = 1'b1;
    endcase
    if (isJump) begin
      taken   = 1'b1;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch sequencing controller: accept, compare, redirect, flush.
// Optional statistics counters are enabled with `define BRANCH_CTRL_STATS_EN.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic            br_is_jump,
  input  logic [XLEN-1:0] br_target,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLT,
  input  logic            abort,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            resolved,
  output logic            resolved_taken,
  output logic            misalign_trap,
  output logic            illegal_br
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  brState_t               state, stateNext;
  logic [2:0]             funct3Q;
  logic                   isJumpQ;
  logic [XLEN-1:0]        targetQ;
  logic [FLUSH_CNT_W-1:0] flushCnt, flushCntNext;
  logic                   accept;
  logic                   taken, illegal;

  logic                   redirectValidNext;
  logic [XLEN-1:0]        redirectPcNext;
  logic                   flushNext;
  logic                   resolvedNext;
  logic                   resolvedTakenNext;
  logic                   misalignNext;
  logic                   illegalNext;

  assign br_ready = (state == ST_IDLE);
  assign BrUn     = (state == ST_CMP) && funct3Q[1];
  assign accept   = br_valid && br_ready && !abort;

  branch_decide uDecide (
    .funct3  (funct3Q),
    .isJump  (isJumpQ),
    .eq      (BrEq),
    .lt      (BrLT),
    .taken   (taken),
    .illegal (illegal)
  );

  // Capture stage: fields latched on the accepting handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3Q <= '0;
      isJumpQ <= 1'b0;
      targetQ <= '0;
    end else if (accept) begin
      funct3Q <= br_funct3;
      isJumpQ <= br_is_jump;
      targetQ <= br_target;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    stateNext         = state;
    flushCntNext      = flushCnt;
    redirectValidNext = 1'b0;
    redirectPcNext    = redirect_pc;
    flushNext         = 1'b0;
    resolvedNext      = 1'b0;
    resolvedTakenNext = 1'b0;
    misalignNext      = 1'b0;
    illegalNext       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (br_valid) stateNext = ST_CMP;
      end
      ST_CMP: begin
        resolvedNext = 1'b1;
        illegalNext  = illegal;
        if (taken && (targetQ[1:0] != 2'b00)) begin
          misalignNext = 1'b1;
          stateNext    = ST_IDLE;
        end else if (taken) begin
          stateNext         = ST_REDIR;
          redirectValidNext = 1'b1;
          redirectPcNext    = targetQ;
          flushNext         = 1'b1;
          resolvedTakenNext = 1'b1;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_REDIR: begin
        stateNext    = ST_FLUSH;
        flushNext    = 1'b1;
        flushCntNext = FLUSH_INIT;
      end
      ST_FLUSH: begin
        if (flushCnt == '0) begin
          stateNext = ST_IDLE;
        end else begin
          flushNext    = 1'b1;
          flushCntNext = flushCnt - 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    // Kill overrides every transition, including an accept in IDLE
    if (abort) begin
      stateNext         = ST_IDLE;
      flushCntNext      = '0;
      redirectValidNext = 1'b0;
      flushNext         = 1'b0;
      resolvedNext      = 1'b0;
      resolvedTakenNext = 1'b0;
      misalignNext      = 1'b0;
      illegalNext       = 1'b0;
    end
  end

  // State and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      flushCnt       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      resolved       <= 1'b0;
      resolved_taken <= 1'b0;
      misalign_trap  <= 1'b0;
      illegal_br     <= 1'b0;
    end else begin
      state          <= stateNext;
      flushCnt       <= flushCntNext;
      redirect_valid <= redirectValidNext;
      redirect_pc    <= redirectPcNext;
      flush          <= flushNext;
      resolved       <= resolvedNext;
      resolved_taken <= resolvedTakenNext;
      misalign_trap  <= misalignNext;
      illegal_br     <= illegalNext;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Counters advance on the same edge that raises the matching pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (resolvedNext)      stat_branches <= stat_branches + 32'd1;
      if (resolvedTakenNext) stat_taken    <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (FLUSH_CYCLES=2); inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_ready, br_is_jump;
  logic [2:0]  br_funct3;
  logic [31:0] br_target;
  logic        BrUn, BrEq, BrLT, abort;
  logic        redirect_valid, flush, resolved, resolved_taken;
  logic        misalign_trap, illegal_br;
  logic [31:0] redirect_pc;
`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_funct3      (br_funct3),
    .br_is_jump     (br_is_jump),
    .br_target      (br_target),
    .BrUn           (BrUn),
    .BrEq           (BrEq),
    .BrLT           (BrLT),
    .abort          (abort),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .resolved       (resolved),
    .resolved_taken (resolved_taken),
    .misalign_trap  (misalign_trap),
    .illegal_br     (illegal_br)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic jmp, input logic [31:0] tgt);
    br_valid   = 1'b1;
    br_funct3  = f3;
    br_is_jump = jmp;
    br_target  = tgt;
  endtask

`ifdef BRANCH_CTRL_STATS_EN
  task automatic runBranch(input logic [2:0] f3, input logic eq, input logic [31:0] tgt);
    int n;
    issue(f3, 1'b0, tgt);
    tick();
    br_valid = 1'b0;
    BrEq     = eq;
    tick();
    BrEq = 1'b0;
    n = 0;
    while (!br_ready && n < 20) begin
      tick();
      n++;
    end
    check("stats_ready_timeout", {31'd0, br_ready}, 32'd1);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    br_valid   = 1'b0;
    br_funct3  = 3'b000;
    br_is_jump = 1'b0;
    br_target  = 32'd0;
    BrEq       = 1'b0;
    BrLT       = 1'b0;
    abort      = 1'b0;
    #3;
    check("rst_ready",    {31'd0, br_ready}, 32'd1);
    check("rst_brun",     {31'd0, BrUn}, 32'd0);
    check("rst_redir",    {31'd0, redirect_valid}, 32'd0);
    check("rst_pc",       redirect_pc, 32'd0);
    check("rst_flush",    {31'd0, flush}, 32'd0);
    check("rst_resolved", {31'd0, resolved}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // BEQ taken, aligned target 0x100
    issue(3'b000, 1'b0, 32'h0000_0100);
    tick();
    br_valid = 1'b0;
    BrEq     = 1'b1;
    check("beq_brun_cmp",  {31'd0, BrUn}, 32'd0);
    check("beq_ready_cmp", {31'd0, br_ready}, 32'd0);
    tick();
    BrEq = 1'b0;
    check("beq_redir_t2",  {31'd0, redirect_valid}, 32'd1);
    check("beq_pc_t2",     redirect_pc, 32'h0000_0100);
    check("beq_flush_t2",  {31'd0, flush}, 32'd1);
    check("beq_res_t2",    {31'd0, resolved}, 32'd1);
    check("beq_taken_t2",  {31'd0, resolved_taken}, 32'd1);
    tick();
    check("beq_redir_t3",  {31'd0, redirect_valid}, 32'd0);
    check("beq_flush_t3",  {31'd0, flush}, 32'd1);
    check("beq_res_t3",    {31'd0, resolved}, 32'd0);
    tick();
    check("beq_flush_t4",  {31'd0, flush}, 32'd1);
    check("beq_ready_t4",  {31'd0, br_ready}, 32'd0);
    tick();
    check("beq_flush_t5",  {31'd0, flush}, 32'd0);
    check("beq_ready_t5",  {31'd0, br_ready}, 32'd1);

    // BLTU not taken, then BEQ queued by decode is accepted at T+2
    issue(3'b110, 1'b0, 32'h0000_0200);
    tick();
    BrLT = 1'b0;
    BrEq = 1'b0;
    issue(3'b000, 1'b0, 32'h0000_0300);
    check("bltu_brun_cmp", {31'd0, BrUn}, 32'd1);
    check("bltu_ready_cmp", {31'd0, br_ready}, 32'd0);
    tick();
    check("bltu_res_t2",   {31'd0, resolved}, 32'd1);
    check("bltu_taken_t2", {31'd0, resolved_taken}, 32'd0);
    check("bltu_flush_t2", {31'd0, flush}, 32'd0);
    check("bltu_redir_t2", {31'd0, redirect_valid}, 32'd0);
    check("bltu_ready_t2", {31'd0, br_ready}, 32'd1);
    tick();
    br_valid = 1'b0;
    check("b2b_accepted",  {31'd0, br_ready}, 32'd0);
    check("b2b_brun",      {31'd0, BrUn}, 32'd0);
    tick();
    check("b2b_res",       {31'd0, resolved}, 32'd1);
    check("b2b_taken",     {31'd0, resolved_taken}, 32'd0);
    tick();

    // JAL to a misaligned target (funct3 010 must not flag illegal)
    issue(3'b010, 1'b1, 32'h0000_0102);
    tick();
    br_valid = 1'b0;
    tick();
    check("jal_misalign",  {31'd0, misalign_trap}, 32'd1);
    check("jal_redir",     {31'd0, redirect_valid}, 32'd0);
    check("jal_res",       {31'd0, resolved}, 32'd1);
    check("jal_taken",     {31'd0, resolved_taken}, 32'd0);
    check("jal_illegal",   {31'd0, illegal_br}, 32'd0);
    check("jal_flush",     {31'd0, flush}, 32'd0);
    tick();
    check("jal_misalign_pulse", {31'd0, misalign_trap}, 32'd0);

    // Illegal funct3 011 with BrEq high
    issue(3'b011, 1'b0, 32'h0000_0400);
    tick();
    br_valid = 1'b0;
    BrEq     = 1'b1;
    tick();
    BrEq = 1'b0;
    check("ill_flag",      {31'd0, illegal_br}, 32'd1);
    check("ill_taken",     {31'd0, resolved_taken}, 32'd0);
    check("ill_redir",     {31'd0, redirect_valid}, 32'd0);
    check("ill_res",       {31'd0, resolved}, 32'd1);
    tick();
    check("ill_pulse",     {31'd0, illegal_br}, 32'd0);

    // BNE taken, aborted during FLUSH
    issue(3'b001, 1'b0, 32'h0000_0440);
    tick();
    br_valid = 1'b0;
    BrEq     = 1'b0;
    tick();
    check("abt_redir_t2",  {31'd0, redirect_valid}, 32'd1);
    check("abt_pc_t2",     redirect_pc, 32'h0000_0440);
    tick();
    check("abt_flush_t3",  {31'd0, flush}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_flush_t4",  {31'd0, flush}, 32'd0);
    check("abt_ready_t4",  {31'd0, br_ready}, 32'd1);

    // Abort in IDLE blocks a simultaneous accept
    abort = 1'b1;
    issue(3'b000, 1'b0, 32'h0000_0500);
    BrEq = 1'b1;
    tick();
    abort    = 1'b0;
    br_valid = 1'b0;
    check("abt_idle_block", {31'd0, br_ready}, 32'd1);
    tick();
    BrEq = 1'b0;
    check("abt_idle_nores", {31'd0, resolved}, 32'd0);
    check("abt_idle_noredir", {31'd0, redirect_valid}, 32'd0);

    // BGE taken, async reset mid-FLUSH
    issue(3'b101, 1'b0, 32'h0000_0600);
    tick();
    br_valid = 1'b0;
    BrLT     = 1'b0;
    tick();
    check("rflush_redir_t2", {31'd0, redirect_valid}, 32'd1);
    tick();
    check("rflush_flush_t3", {31'd0, flush}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rflush_flush",  {31'd0, flush}, 32'd0);
    check("rflush_ready",  {31'd0, br_ready}, 32'd1);
    check("rflush_pc",     redirect_pc, 32'd0);
    check("rflush_redir",  {31'd0, redirect_valid}, 32'd0);
    check("rflush_res",    {31'd0, resolved}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

`ifdef BRANCH_CTRL_STATS_EN
    runBranch(3'b000, 1'b1, 32'h0000_0700);
    runBranch(3'b001, 1'b1, 32'h0000_0704);
    runBranch(3'b000, 1'b1, 32'h0000_0708);
    runBranch(3'b001, 1'b1, 32'h0000_070c);
    runBranch(3'b000, 1'b1, 32'h0000_0710);
    tick();
    check("stat_branches", stat_branches, 32'd5);
    check("stat_taken",    stat_taken, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
